jpeg_bitstream_unstuffer: RTL

//   Upstream feeder for the Huffman decoder. Accepts entropy-coded JPEG bytes over a

---
 rtl/jpeg_bitstream_unstuffer_if.sv | 11 +
 rtl/jpeg_bitstream_unstuffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_unstuffer_if.sv
// Byte handshake between the entropy-coded byte source and the unstuffer.
// The source drives byte_in/byte_valid; the unstuffer answers with byte_ready.
// A byte transfers on a rising edge where byte_valid and byte_ready are both high.
interface jpeg_bitstream_unstuffer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/jpeg_bitstream_unstuffer.sv
// JPEG entropy-coded segment unstuffer.
// Removes 0xFF00 stuffing, reports RSTn / EOI / illegal markers as one-cycle
// pulses, and serialises data bytes one bit at a time for the Huffman decoder.
// Each data byte costs one LOAD bubble, so peak throughput is 8 bits per 9 cycles.
module jpeg_bitstream_unstuffer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  jpeg_bitstream_unstuffer_if.slave        byte_if,
  input  logic                             bit_ready,
  input  logic                             flush,
  output logic                             next_bit,
  output logic                             is_new,
  output logic [3:0]                       bits_left,
  output logic                             rst_marker,
  output logic                             eoi,
  output logic                             marker_err,
  output logic [7:0]                       marker_code
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    FF_WAIT = 2'd1,
    SHIFT   = 2'd2,
    HALT    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bits_left_q, bits_left_d;
  logic       rst_marker_q, rst_marker_d;
  logic       eoi_q, eoi_d;
  logic       marker_err_q, marker_err_d;
  logic [7:0] marker_code_q, marker_code_d;

  logic byte_ready_w;
  logic xfer;
  logic take;

  // Handshake and bit-consume strobes; flush blocks both so nothing is lost mid-realign.
  always_comb begin
    byte_ready_w = ((state_q == LOAD) || (state_q == FF_WAIT)) && !flush;
    xfer         = byte_ready_w && byte_if.byte_valid;
    take         = (state_q == SHIFT) && bit_ready && !flush;
  end

  assign byte_if.byte_ready = byte_ready_w;
  assign is_new             = take;
  assign next_bit           = MSB_FIRST ? shift_q[7] : shift_q[0];
  assign bits_left          = bits_left_q;
  assign rst_marker         = rst_marker_q;
  assign eoi                = eoi_q;
  assign marker_err         = marker_err_q;
  assign marker_code        = marker_code_q;

  // Next-state logic: byte classification, stuffing removal and bit shifting.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned;
    // a missing default would silently infer a latch.
    state_d       = state_q;
    shift_d       = shift_q;
    bits_left_d   = bits_left_q;
    rst_marker_d  = 1'b0;
    eoi_d         = 1'b0;
    marker_err_d  = 1'b0;
    marker_code_d = marker_code_q;

    if (flush) begin
      // Realign: drop the rest of the byte and any half-seen 0xFF.
      state_d     = LOAD;
      shift_d     = 8'h00;
      bits_left_d = 4'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer) begin
            if (byte_if.byte_in == 8'hFF) begin
              state_d = FF_WAIT;
            end else begin
              shift_d     = byte_if.byte_in;
              bits_left_d = 4'd8;
              state_d     = SHIFT;
            end
          end
        end
        FF_WAIT: begin
          if (xfer) begin
            if (byte_if.byte_in == 8'h00) begin
              // Stuffed zero: the preceding 0xFF was data.
              shift_d     = 8'hFF;
              bits_left_d = 4'd8;
              state_d     = SHIFT;
            end else if (byte_if.byte_in[7:3] == 5'b11010) begin
              rst_marker_d  = 1'b1;
              marker_code_d = byte_if.byte_in;
              state_d       = LOAD;
            end else if (byte_if.byte_in == 8'hD9) begin
              eoi_d         = 1'b1;
              marker_code_d = byte_if.byte_in;
              state_d       = HALT;
            end else if (byte_if.byte_in == 8'hFF) begin
              // Fill byte: still waiting for the marker code.
              state_d = FF_WAIT;
            end else begin
              marker_err_d  = 1'b1;
              marker_code_d = byte_if.byte_in;
              state_d       = HALT;
            end
          end
        end
        SHIFT: begin
          if (take) begin
            shift_d     = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
            bits_left_d = bits_left_q - 4'd1;
            if (bits_left_q == 4'd1) begin
              state_d = LOAD;
            end
          end
        end
        default: begin
          // HALT: wait for flush or reset.
          state_d = HALT;
        end
      endcase
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q       <= LOAD;
      shift_q       <= 8'h00;
      bits_left_q   <= 4'd0;
      rst_marker_q  <= 1'b0;
      eoi_q         <= 1'b0;
      marker_err_q  <= 1'b0;
      marker_code_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bits_left_q   <= bits_left_d;
      rst_marker_q  <= rst_marker_d;
      eoi_q         <= eoi_d;
      marker_err_q  <= marker_err_d;
      marker_code_q <= marker_code_d;
    end
  end

endmodule
